reduce_tx: RTL and testbench

Transmit side of the collective-reduction datapath. Accepts completed reduction packets from the reduction table (`done` pulse plus 64-bit output packet) and buffers them. Non-root nodes forward each result to their parent via a valid/ready network port. The root node delivers the result to the host port and, when configured, re-issues it down as broadcast packets (allreduce).

---
 rtl/reduce_pkg.sv | 59 +++++
 rtl/reduce_tx_fifo.sv | 66 ++++++
 rtl/reduce_tx.sv | 206 ++++++++++++++++++++
 tb/tb_reduce_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// reduce_pkg: packet field layout, FSM states and algorithm encodings for the reduction TX path.
// The ST_BCAST state exists only when ALLREDUCE_BCAST_EN is defined.
package reduce_pkg;

    localparam int unsigned PKT_W         = 64;

    localparam int unsigned F_VALID       = 63;
    localparam int unsigned F_RED         = 62;
    localparam int unsigned F_SRC_LSB     = 59;
    localparam int unsigned F_DST_LSB     = 56;
    localparam int unsigned F_TYPE_LSB    = 52;
    localparam int unsigned F_ALG_LSB     = 50;
    localparam int unsigned F_INDEX_LSB   = 46;
    localparam int unsigned F_COMM_LSB    = 43;
    localparam int unsigned F_ROOT_LSB    = 40;
    localparam int unsigned F_RANK_LSB    = 37;
    localparam int unsigned F_OP_LSB      = 32;
    localparam int unsigned F_PAYLOAD_LSB = 0;

    localparam int unsigned NODE_W        = 3;
    localparam int unsigned TYPE_W        = 4;
    localparam int unsigned ALG_W         = 2;
    localparam int unsigned INDEX_W       = 4;
    localparam int unsigned OP_W          = 5;
    localparam int unsigned PAYLOAD_W     = 32;

    localparam logic [TYPE_W-1:0] BCAST_TYPE_DEFAULT = 4'b0010;

    localparam logic [ALG_W-1:0] ALG_FLAT  = 2'b00;
    localparam logic [ALG_W-1:0] ALG_BTREE = 2'b01;

    typedef logic [NODE_W-1:0] node_t;
    typedef logic [PKT_W-1:0]  pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NET   = 2'd1,
        ST_HOST  = 2'd2
`ifdef ALLREDUCE_BCAST_EN
        ,
        ST_BCAST = 2'd3
`endif
    } tx_state_e;

    // Node ids are 3 bits; all arithmetic deliberately wraps mod 8.
    function automatic node_t parent_of(input logic [ALG_W-1:0] alg,
                                        input node_t rank,
                                        input node_t root);
        node_t rel;
        node_t up;
        rel = rank - root;
        up  = (rel - node_t'(1)) >> 1;
        if (alg == ALG_BTREE) begin
            return up + root;
        end
        return root;
    endfunction

endpackage

// File: rtl/reduce_tx_fifo.sv
// reduce_tx_fifo: synchronous FIFO for completed reduction packets.
// Caller guarantees push only when not full (or with a same-cycle pop) and pop only when non-empty.
module reduce_tx_fifo
    import reduce_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = PKT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flags are registered from the next occupancy so they reflect this cycle's push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/reduce_tx.sv
// reduce_tx: buffers completed reduction packets, forwards them to the parent or host,
// and (with ALLREDUCE_BCAST_EN defined) re-issues root results as broadcast packets.
module reduce_tx
    import reduce_pkg::*;
#(
    parameter int unsigned      DEPTH      = 4,
    parameter logic [TYPE_W-1:0] BCAST_TYPE = BCAST_TYPE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PKT_W-1:0] in_packet,
    output logic             in_full,
    output logic             net_valid,
    input  logic             net_ready,
    output logic [PKT_W-1:0] net_packet,
    output logic             host_valid,
    input  logic             host_ready,
    output logic [PKT_W-1:0] host_packet,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_e        state;
    tx_state_e        state_d;
    pkt_t             cur;
    pkt_t             cur_d;

    logic             fifo_full;
    logic             fifo_empty;
    pkt_t             fifo_head;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    occ_next;

    logic             push_req;
    logic             push_ok;
    logic             pop;

    logic             net_valid_d;
    logic             host_valid_d;
    logic             overflow_d;
    logic             busy_d;
    pkt_t             net_packet_d;
    pkt_t             host_packet_d;

`ifdef ALLREDUCE_BCAST_EN
    node_t            bidx;
    node_t            bidx_d;
`endif

    function automatic pkt_t to_net(input pkt_t p);
        pkt_t q;
        q = p;
        q[F_VALID] = 1'b1;
        q[F_RED]   = 1'b1;
        q[F_SRC_LSB +: NODE_W] = p[F_RANK_LSB +: NODE_W];
        q[F_DST_LSB +: NODE_W] = parent_of(p[F_ALG_LSB +: ALG_W],
                                           p[F_RANK_LSB +: NODE_W],
                                           p[F_ROOT_LSB +: NODE_W]);
        return q;
    endfunction

    function automatic pkt_t to_host(input pkt_t p);
        pkt_t q;
        q = p;
        q[F_VALID] = 1'b1;
        q[F_RED]   = 1'b0;
        return q;
    endfunction

`ifdef ALLREDUCE_BCAST_EN
    function automatic pkt_t to_bcast(input pkt_t p, input node_t k);
        pkt_t q;
        q = p;
        q[F_VALID] = 1'b1;
        q[F_RED]   = 1'b0;
        q[F_TYPE_LSB +: TYPE_W] = BCAST_TYPE;
        q[F_SRC_LSB +: NODE_W]  = p[F_ROOT_LSB +: NODE_W];
        q[F_DST_LSB +: NODE_W]  = p[F_ROOT_LSB +: NODE_W] + k;
        return q;
    endfunction
`endif

    reduce_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (in_packet),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // A push into a full buffer is still accepted when the head leaves in the same cycle.
    assign push_req   = in_valid && in_packet[F_VALID];
    assign push_ok    = push_req && (!fifo_full || pop);
    assign overflow_d = overflow || (push_req && fifo_full && !pop);
    assign occ_next   = fifo_count + CW'(push_ok) - CW'(pop);
    assign busy_d     = (state_d != ST_IDLE) || (occ_next != '0);
    assign in_full    = fifo_full;

    always_comb begin
        state_d       = state;
        cur_d         = cur;
        net_valid_d   = net_valid;
        net_packet_d  = net_packet;
        host_valid_d  = host_valid;
        host_packet_d = host_packet;
        pop           = 1'b0;
`ifdef ALLREDUCE_BCAST_EN
        bidx_d        = bidx;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cur_d = fifo_head;
                    if (fifo_head[F_RANK_LSB +: NODE_W] == fifo_head[F_ROOT_LSB +: NODE_W]) begin
                        state_d       = ST_HOST;
                        host_valid_d  = 1'b1;
                        host_packet_d = to_host(fifo_head);
                    end else begin
                        state_d      = ST_NET;
                        net_valid_d  = 1'b1;
                        net_packet_d = to_net(fifo_head);
                    end
                end
            end
            ST_NET: begin
                if (net_ready) begin
                    pop         = 1'b1;
                    net_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (host_ready) begin
                    pop          = 1'b1;
                    host_valid_d = 1'b0;
                    state_d      = ST_IDLE;
`ifdef ALLREDUCE_BCAST_EN
                    // First broadcast is staged here so it follows the host handshake without a bubble.
                    if (cur[F_COMM_LSB +: NODE_W] >= node_t'(2)) begin
                        state_d      = ST_BCAST;
                        bidx_d       = node_t'(1);
                        net_valid_d  = 1'b1;
                        net_packet_d = to_bcast(cur, node_t'(1));
                    end
`endif
                end
            end
`ifdef ALLREDUCE_BCAST_EN
            ST_BCAST: begin
                if (net_ready) begin
                    if (bidx == cur[F_COMM_LSB +: NODE_W] - node_t'(1)) begin
                        state_d     = ST_IDLE;
                        bidx_d      = '0;
                        net_valid_d = 1'b0;
                    end else begin
                        bidx_d       = bidx + node_t'(1);
                        net_packet_d = to_bcast(cur, bidx + node_t'(1));
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur         <= '0;
            net_valid   <= 1'b0;
            net_packet  <= '0;
            host_valid  <= 1'b0;
            host_packet <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
`ifdef ALLREDUCE_BCAST_EN
            bidx        <= '0;
`endif
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            net_valid   <= net_valid_d;
            net_packet  <= net_packet_d;
            host_valid  <= host_valid_d;
            host_packet <= host_packet_d;
            overflow    <= overflow_d;
            busy        <= busy_d;
`ifdef ALLREDUCE_BCAST_EN
            bidx        <= bidx_d;
`endif
        end
    end

endmodule

// File: tb/tb_reduce_tx.sv
// tb_reduce_tx: directed and randomized checks of reduce_tx against a packet-level reference model.
// Broadcast expectations follow ALLREDUCE_BCAST_EN, matching the RTL build.
module tb_reduce_tx;

    localparam logic [3:0] TB_BCAST = 4'b0010;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        in_valid   = 1'b0;
    logic [63:0] in_packet  = '0;
    logic        net_ready  = 1'b0;
    logic        host_ready = 1'b0;
    logic        in_full;
    logic        net_valid;
    logic [63:0] net_packet;
    logic        host_valid;
    logic [63:0] host_packet;
    logic        overflow;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] exp_net_q[$];
    logic [63:0] exp_host_q[$];

    reduce_tx #(
        .DEPTH      (4),
        .BCAST_TYPE (TB_BCAST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_packet   (in_packet),
        .in_full     (in_full),
        .net_valid   (net_valid),
        .net_ready   (net_ready),
        .net_packet  (net_packet),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_packet (host_packet),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input int rank, input int root, input int comm,
                                       input int alg, input logic [31:0] payload);
        logic [63:0] p;
        p = {$urandom(), $urandom()};
        p[63]    = 1'b1;
        p[39:37] = 3'(rank);
        p[42:40] = 3'(root);
        p[45:43] = 3'(comm);
        p[51:50] = 2'(alg);
        p[31:0]  = payload;
        return p;
    endfunction

    // Upward packet: parent from node arithmetic mod 8.
    function automatic logic [63:0] exp_up(input logic [63:0] p);
        int rank, root, rel, par;
        logic [63:0] q;
        rank = int'(p[39:37]);
        root = int'(p[42:40]);
        if (p[51:50] == 2'b01) begin
            rel = (rank - root + 8) % 8;
            par = (((rel + 7) % 8) / 2 + root) % 8;
        end else begin
            par = root;
        end
        q = p;
        q[63]    = 1'b1;
        q[62]    = 1'b1;
        q[61:59] = p[39:37];
        q[58:56] = 3'(par);
        return q;
    endfunction

    task automatic model_push(input logic [63:0] p);
        logic [63:0] q;
        int root, comm;
        root = int'(p[42:40]);
        comm = int'(p[45:43]);
        if (p[39:37] == p[42:40]) begin
            q = p;
            q[62] = 1'b0;
            exp_host_q.push_back(q);
`ifdef ALLREDUCE_BCAST_EN
            for (int k = 1; k < comm; k++) begin
                q = p;
                q[62]    = 1'b0;
                q[55:52] = TB_BCAST;
                q[61:59] = p[42:40];
                q[58:56] = 3'((root + k) % 8);
                exp_net_q.push_back(q);
            end
`else
            if (comm > 8) $display("unreachable root=%0d", root);
`endif
        end else begin
            exp_net_q.push_back(exp_up(p));
        end
    endtask

    task automatic push(input logic [63:0] p);
        in_valid  = 1'b1;
        in_packet = p;
        step();
        in_valid  = 1'b0;
        if (p[63]) model_push(p);
    endtask

    // Run until the DUT is idle and every expected packet has appeared.
    task automatic drain(input int budget, input bit rand_ready);
        int   cyc;
        logic stall_n, stall_h;
        logic [63:0] held_n, held_h;
        cyc = 0;
        stall_n = 1'b0;
        stall_h = 1'b0;
        held_n = '0;
        held_h = '0;
        while (busy || exp_net_q.size() != 0 || exp_host_q.size() != 0) begin
            if (cyc >= budget) begin
                chk("drain_left", 64'(exp_net_q.size() + exp_host_q.size()), 64'(0));
                chk("drain_busy", 64'(busy), 64'(0));
                break;
            end
            net_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            host_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_n) begin
                chk("net_hold_valid", 64'(net_valid), 64'(1));
                chk("net_hold_pkt", net_packet, held_n);
            end
            if (stall_h) begin
                chk("host_hold_valid", 64'(host_valid), 64'(1));
                chk("host_hold_pkt", host_packet, held_h);
            end
            if (net_valid && net_ready) begin
                if (exp_net_q.size() == 0) chk("net_extra", 64'(net_valid), 64'(0));
                else chk("net_pkt", net_packet, exp_net_q.pop_front());
            end
            if (host_valid && host_ready) begin
                if (exp_host_q.size() == 0) chk("host_extra", 64'(host_valid), 64'(0));
                else chk("host_pkt", host_packet, exp_host_q.pop_front());
            end
            stall_n = net_valid && !net_ready;
            stall_h = host_valid && !host_ready;
            held_n  = net_packet;
            held_h  = host_packet;
            step();
            cyc++;
        end
        net_ready  = 1'b0;
        host_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] held;
        logic [63:0] ovf [5];
        int          n, root, rank;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        chk("rst_net_valid", 64'(net_valid), 64'(0));
        chk("rst_host_valid", 64'(host_valid), 64'(0));
        chk("rst_net_packet", net_packet, 64'(0));
        chk("rst_host_packet", host_packet, 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_full", 64'(in_full), 64'(0));
        rst = 1'b0;
        step();

        // Non-root flat: latency and field rewrite
        net_ready = 1'b1;
        p = mk(3, 0, 4, 0, 32'h3F800000);
        push(p);
        chk("flat_t1_valid", 64'(net_valid), 64'(0));
        step();
        chk("flat_t2_valid", 64'(net_valid), 64'(1));
        chk("flat_dst", 64'(net_packet[58:56]), 64'(0));
        chk("flat_src", 64'(net_packet[61:59]), 64'(3));
        chk("flat_red", 64'(net_packet[62]), 64'(1));
        chk("flat_payload", 64'(net_packet[31:0]), 64'(32'h3F800000));
        chk("flat_pkt", net_packet, exp_net_q.pop_front());
        step();
        chk("flat_done_valid", 64'(net_valid), 64'(0));
        chk("flat_busy", 64'(busy), 64'(0));

        // Binary tree parents, including wrap-around
        net_ready = 1'b0;
        push(mk(7, 2, 4, 1, $urandom()));
        step();
        chk("btree_dst_4", 64'(net_packet[58:56]), 64'(4));
        drain(50, 1'b0);
        push(mk(0, 6, 4, 1, $urandom()));
        step();
        chk("btree_dst_wrap", 64'(net_packet[58:56]), 64'(6));
        drain(50, 1'b0);

        // Backpressure: held stable for 5 cycles
        net_ready = 1'b0;
        push(mk(5, 1, 3, 0, $urandom()));
        step();
        chk("bp_valid", 64'(net_valid), 64'(1));
        held = net_packet;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 64'(net_valid), 64'(1));
            chk("bp_hold_pkt", net_packet, held);
        end
        chk("bp_busy", 64'(busy), 64'(1));
        drain(20, 1'b0);
        chk("bp_after_valid", 64'(net_valid), 64'(0));

        // Ignored packet (valid bit clear)
        p = mk(2, 0, 4, 0, $urandom());
        p[63] = 1'b0;
        push(p);
        step();
        step();
        chk("ign_net_valid", 64'(net_valid), 64'(0));
        chk("ign_busy", 64'(busy), 64'(0));

        // Overflow: 5 pushes into a 4-deep buffer with no pops
        net_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            root   = int'($urandom_range(0, 7));
            ovf[i] = mk((root + 1 + int'($urandom_range(0, 6))) % 8, root,
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom());
        end
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_packet = ovf[i];
            step();
            if (i < 4) model_push(ovf[i]);
            if (i == 2) chk("ovf_not_full_3", 64'(in_full), 64'(0));
            if (i == 3) begin
                chk("ovf_full_4", 64'(in_full), 64'(1));
                chk("ovf_clear_4", 64'(overflow), 64'(0));
            end
        end
        in_valid = 1'b0;
        chk("ovf_set_5", 64'(overflow), 64'(1));
        drain(200, 1'b1);

        // Root: host delivery, then broadcast when built in
        host_ready = 1'b1;
        net_ready  = 1'b1;
        push(mk(1, 1, 4, 0, $urandom()));
        step();
        chk("root_host_valid", 64'(host_valid), 64'(1));
        chk("root_host_red", 64'(host_packet[62]), 64'(0));
        chk("root_host_pkt", host_packet, exp_host_q.pop_front());
`ifdef ALLREDUCE_BCAST_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bcast_valid", 64'(net_valid), 64'(1));
            chk("bcast_dst", 64'(net_packet[58:56]), 64'(2 + k));
            chk("bcast_type", 64'(net_packet[55:52]), 64'(TB_BCAST));
            chk("bcast_pkt", net_packet, exp_net_q.pop_front());
        end
`endif
        step();
        chk("root_end_net", 64'(net_valid), 64'(0));
        chk("root_end_host", 64'(host_valid), 64'(0));
        chk("root_end_busy", 64'(busy), 64'(0));

        // Commsize 1: host only
        push(mk(4, 4, 1, 1, $urandom()));
        step();
        chk("c1_host_pkt", host_packet, exp_host_q.pop_front());
        step();
        chk("c1_net_valid", 64'(net_valid), 64'(0));
        chk("c1_busy", 64'(busy), 64'(0));
        host_ready = 1'b0;
        net_ready  = 1'b0;

        // Randomized bursts of up to DEPTH packets with random readiness
        for (int it = 0; it < 40; it++) begin
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) begin
                root = int'($urandom_range(0, 7));
                rank = ($urandom_range(0, 3) == 0) ? root : int'($urandom_range(0, 7));
                push(mk(rank, root, int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 3)), $urandom()));
            end
            drain(400, 1'b1);
        end

        // Reset in the middle of a transfer
        net_ready  = 1'b1;
        host_ready = 1'b1;
`ifdef ALLREDUCE_BCAST_EN
        push(mk(1, 1, 4, 0, $urandom()));
        step();
        step();
        step();
`else
        net_ready = 1'b0;
        push(mk(3, 0, 4, 0, $urandom()));
        push(mk(5, 0, 4, 0, $urandom()));
        step();
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_net_q.delete();
        exp_host_q.delete();
        chk("mrst_net_valid", 64'(net_valid), 64'(0));
        chk("mrst_net_packet", net_packet, 64'(0));
        chk("mrst_host_valid", 64'(host_valid), 64'(0));
        chk("mrst_overflow", 64'(overflow), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        net_ready = 1'b1;
        repeat (4) step();
        chk("mrst_quiet_net", 64'(net_valid), 64'(0));
        chk("mrst_quiet_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
